// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong ball datapath.
//   - ball_state_e : ball FSM encoding reported on the state output
//   - ARENA_* / SERVE_* : default arena bounds and serve position
//   - paddle_dir_y : vertical direction forced by a paddle-half contact
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_SCORED = 2'd2
  } ball_state_e;

  localparam int ARENA_X_MIN = 10;
  localparam int ARENA_X_MAX = 210;
  localparam int ARENA_Y_MIN = 175;
  localparam int ARENA_Y_MAX = 310;
  localparam int SERVE_X     = 20;
  localparam int SERVE_Y     = 240;

  // Top half pushes the ball up, bottom half down; touching both reverses it.
  function automatic logic paddle_dir_y(input logic [1:0] hit, input logic dir);
    logic res;
    case (hit)
      2'b10:   res = 1'b0;
      2'b01:   res = 1'b1;
      2'b11:   res = ~dir;
      default: res = dir;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// axis_stepper: one bounded step along a single axis.
//   pos/dir/step : current position, direction (1 = increasing), step size
//   min_pos/max_pos : inclusive bounds
//   next_pos     : stepped position, clamped to the bound that was reached
//   hit_bound    : the step reached or crossed the bound in the travel direction
module axis_stepper #(
  parameter int W      = 10,
  parameter int STEP_W = 3
) (
  input  logic [W-1:0]      pos,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [W-1:0]      min_pos,
  input  logic [W-1:0]      max_pos,
  output logic [W-1:0]      next_pos,
  output logic              hit_bound
);

  logic [W:0] pos_w_s;
  logic [W:0] step_w_s;
  logic [W:0] sum_w_s;
  logic [W:0] lim_w_s;

  // Step one bit wider than the coordinate; the decreasing test is
  // rearranged (pos <= min + step) so the subtraction can never underflow.
  always_comb begin
    pos_w_s  = {1'b0, pos};
    step_w_s = (W+1)'(step);
    if (dir) begin
      sum_w_s   = pos_w_s + step_w_s;
      lim_w_s   = {1'b0, max_pos};
      hit_bound = (sum_w_s >= lim_w_s);
    end else begin
      sum_w_s   = pos_w_s - step_w_s;
      lim_w_s   = {1'b0, min_pos};
      hit_bound = (pos_w_s <= (lim_w_s + step_w_s));
    end
    if (hit_bound) begin
      next_pos = lim_w_s[W-1:0];
    end else begin
      next_pos = sum_w_s[W-1:0];
    end
  end

endmodule

// File: rtl/ball_kinematics.sv
// ball_kinematics: pong ball position/direction/speed state machine.
//   clock, reset (async, active-high), tick (frame step strobe)
//   serve/serve_dir : launch request and initial X direction (1 = right)
//   hit_x           : paddle face contact; hit_y[1]/[0] top/bottom half contact
//   ball_x/ball_y, dir_x (1 = right), dir_y (1 = down), speed_x, state
//   miss_left/miss_right/bounce : single-cycle event pulses
// All outputs come straight from flops.
module ball_kinematics
  import pong_pkg::*;
#(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int X_MIN      = ARENA_X_MIN,
  parameter int X_MAX      = ARENA_X_MAX,
  parameter int Y_MIN      = ARENA_Y_MIN,
  parameter int Y_MAX      = ARENA_Y_MAX,
  parameter int X_START    = SERVE_X,
  parameter int Y_START    = SERVE_Y,
  parameter int SPD_W      = 3,
  parameter int SPD_BASE   = 1,
  parameter int SPD_MAX    = 4,
  parameter int RALLY_STEP = 4,
  parameter int HOLD_TICKS = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             serve,
  input  logic             serve_dir,
  input  logic             hit_x,
  input  logic [1:0]       hit_y,
  output logic [X_W-1:0]   ball_x,
  output logic [Y_W-1:0]   ball_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic [SPD_W-1:0] speed_x,
  output logic [1:0]       state,
  output logic             miss_left,
  output logic             miss_right,
  output logic             bounce
);

  localparam int RALLY_W = $clog2(RALLY_STEP + 1);
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);

  localparam logic [X_W-1:0]     X_MIN_C    = X_W'(X_MIN);
  localparam logic [X_W-1:0]     X_MAX_C    = X_W'(X_MAX);
  localparam logic [Y_W-1:0]     Y_MIN_C    = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]     Y_MAX_C    = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]     X_START_C  = X_W'(X_START);
  localparam logic [Y_W-1:0]     Y_START_C  = Y_W'(Y_START);
  localparam logic [SPD_W-1:0]   SPD_BASE_C = SPD_W'(SPD_BASE);
  localparam logic [SPD_W-1:0]   SPD_MAX_C  = SPD_W'(SPD_MAX);
  localparam logic [RALLY_W-1:0] RALLY_C    = RALLY_W'(RALLY_STEP);
  localparam logic [HOLD_W-1:0]  HOLD_LAST_C = HOLD_W'(HOLD_TICKS - 1);

  ball_state_e        state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [RALLY_W-1:0] rally_q, rally_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               miss_left_q, miss_left_d;
  logic               miss_right_q, miss_right_d;
  logic               bounce_q, bounce_d;

  logic [X_W-1:0]     x_step_s;
  logic               x_hit_s;
  logic [Y_W-1:0]     y_step_s;
  logic               y_hit_s;
  logic [RALLY_W-1:0] rally_inc_s;

  axis_stepper #(.W(X_W), .STEP_W(SPD_W)) u_step_x (
    .pos       (x_q),
    .dir       (dir_x_q),
    .step      (speed_q),
    .min_pos   (X_MIN_C),
    .max_pos   (X_MAX_C),
    .next_pos  (x_step_s),
    .hit_bound (x_hit_s)
  );

  axis_stepper #(.W(Y_W), .STEP_W(1)) u_step_y (
    .pos       (y_q),
    .dir       (dir_y_q),
    .step      (1'b1),
    .min_pos   (Y_MIN_C),
    .max_pos   (Y_MAX_C),
    .next_pos  (y_step_s),
    .hit_bound (y_hit_s)
  );

  assign rally_inc_s = rally_q + RALLY_W'(1);

  // Next-state logic for the ball FSM and its datapath.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    speed_d      = speed_q;
    rally_d      = rally_q;
    hold_d       = hold_q;
    miss_left_d  = 1'b0;
    miss_right_d = 1'b0;
    bounce_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Serve does not wait for a tick.
        if (serve) begin
          state_d = ST_MOVE;
          dir_x_d = serve_dir;
          dir_y_d = 1'b1;
          speed_d = SPD_BASE_C;
          rally_d = {RALLY_W{1'b0}};
          hold_d  = {HOLD_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (tick) begin
          // Paddle-half contact steers Y and holds it for this tick.
          if (hit_y != 2'b00) begin
            dir_y_d = paddle_dir_y(hit_y, dir_y_q);
          end else if (y_hit_s) begin
            y_d      = y_step_s;
            dir_y_d  = ~dir_y_q;
            bounce_d = 1'b1;
          end else begin
            y_d = y_step_s;
          end
          // A paddle return outranks the miss test on the same tick.
          if (hit_x) begin
            dir_x_d  = ~dir_x_q;
            bounce_d = 1'b1;
            if (rally_inc_s == RALLY_C) begin
              rally_d = {RALLY_W{1'b0}};
              if (speed_q < SPD_MAX_C) begin
                speed_d = speed_q + SPD_W'(1);
              end else begin
                speed_d = speed_q;
              end
            end else begin
              rally_d = rally_inc_s;
            end
          end else if (x_hit_s) begin
            x_d          = x_step_s;
            state_d      = ST_SCORED;
            hold_d       = {HOLD_W{1'b0}};
            miss_left_d  = ~dir_x_q;
            miss_right_d = dir_x_q;
          end else begin
            x_d = x_step_s;
          end
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_SCORED: begin
        if (tick) begin
          if (hold_q == HOLD_LAST_C) begin
            state_d = ST_IDLE;
            x_d     = X_START_C;
            y_d     = Y_START_C;
            rally_d = {RALLY_W{1'b0}};
            hold_d  = {HOLD_W{1'b0}};
            speed_d = SPD_BASE_C;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else begin
          state_d = ST_SCORED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= X_START_C;
      y_q          <= Y_START_C;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      speed_q      <= SPD_BASE_C;
      rally_q      <= {RALLY_W{1'b0}};
      hold_q       <= {HOLD_W{1'b0}};
      miss_left_q  <= 1'b0;
      miss_right_q <= 1'b0;
      bounce_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      speed_q      <= speed_d;
      rally_q      <= rally_d;
      hold_q       <= hold_d;
      miss_left_q  <= miss_left_d;
      miss_right_q <= miss_right_d;
      bounce_q     <= bounce_d;
    end
  end

  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign speed_x    = speed_q;
  assign state      = state_q;
  assign miss_left  = miss_left_q;
  assign miss_right = miss_right_q;
  assign bounce     = bounce_q;

endmodule

// File: tb/tb_ball_kinematics.sv
// tb_ball_kinematics: directed scoreboard bench for ball_kinematics.
// Expected values are queued as each step is driven and compared after the
// clock edge (or settle delay) that should produce them.
module tb_ball_kinematics;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       serve = 1'b0;
  logic       serve_dir = 1'b0;
  logic       hit_x = 1'b0;
  logic [1:0] hit_y = 2'b00;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic [2:0] speed_x;
  logic [1:0] state;
  logic       miss_left;
  logic       miss_right;
  logic       bounce;

  ball_kinematics dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .serve      (serve),
    .serve_dir  (serve_dir),
    .hit_x      (hit_x),
    .hit_y      (hit_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .speed_x    (speed_x),
    .state      (state),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .bounce     (bounce)
  );

  always #5 clock = ~clock;

  localparam int S_X = 0, S_Y = 1, S_DX = 2, S_DY = 3, S_SPD = 4;
  localparam int S_ST = 5, S_ML = 6, S_MR = 7, S_BN = 8;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic integer observe(input int sel);
    case (sel)
      S_X:     return integer'(ball_x);
      S_Y:     return integer'(ball_y);
      S_DX:    return integer'(dir_x);
      S_DY:    return integer'(dir_y);
      S_SPD:   return integer'(speed_x);
      S_ST:    return integer'(state);
      S_ML:    return integer'(miss_left);
      S_MR:    return integer'(miss_right);
      S_BN:    return integer'(bounce);
      default: return 'x;
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t   e;
      integer obs;
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  task automatic want_reset_values(input string pfx);
    want({pfx, "_x"}, S_X, 20);
    want({pfx, "_y"}, S_Y, 240);
    want({pfx, "_dx"}, S_DX, 1);
    want({pfx, "_dy"}, S_DY, 1);
    want({pfx, "_spd"}, S_SPD, 1);
    want({pfx, "_state"}, S_ST, 0);
    want({pfx, "_ml"}, S_ML, 0);
    want({pfx, "_mr"}, S_MR, 0);
    want({pfx, "_bounce"}, S_BN, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    want_reset_values("rst");
    drain();
    reset = 1'b0;

    // Tick in IDLE leaves the ball parked.
    tick = 1'b1;
    want("idle_tick_x", S_X, 20);
    want("idle_tick_state", S_ST, 0);
    clk1();
    drain();
    tick = 1'b0;

    // Serve right, then five ticks.
    serve = 1'b1;
    serve_dir = 1'b1;
    want("serve_state", S_ST, 1);
    want("serve_dx", S_DX, 1);
    want("serve_dy", S_DY, 1);
    want("serve_spd", S_SPD, 1);
    want("serve_x", S_X, 20);
    clk1();
    drain();
    serve = 1'b0;
    tick = 1'b1;
    want("tick5_x", S_X, 25);
    want("tick5_y", S_Y, 245);
    want("tick5_state", S_ST, 1);
    repeat (5) clk1();
    drain();
    tick = 1'b0;
    want("notick_x", S_X, 25);
    want("notick_y", S_Y, 245);
    clk1();
    drain();

    // Both paddle halves while moving down: reverse, y held.
    tick = 1'b1;
    hit_y = 2'b11;
    want("hy11_dy", S_DY, 0);
    want("hy11_y", S_Y, 245);
    want("hy11_x", S_X, 26);
    clk1();
    drain();
    hit_y = 2'b01;
    want("hy01_dy", S_DY, 1);
    want("hy01_y", S_Y, 245);
    clk1();
    drain();
    hit_y = 2'b00;

    // Run down to 309, then bounce off Y_MAX.
    want("pre_bot_y", S_Y, 309);
    want("pre_bot_x", S_X, 91);
    repeat (64) clk1();
    drain();
    want("bot_y", S_Y, 310);
    want("bot_dy", S_DY, 0);
    want("bot_bounce", S_BN, 1);
    want("bot_x", S_X, 92);
    clk1();
    drain();
    tick = 1'b0;
    serve = 1'b1;
    serve_dir = 1'b0;
    want("bot_bounce_clr", S_BN, 0);
    want("serve_ign_state", S_ST, 1);
    want("serve_ign_dx", S_DX, 1);
    clk1();
    drain();
    serve = 1'b0;
    tick = 1'b1;
    want("up_y", S_Y, 309);
    want("up_bounce", S_BN, 0);
    clk1();
    drain();
    tick = 1'b0;

    // Reset mid-flight takes effect without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    want_reset_values("midrst");
    drain();
    #1;
    reset = 1'b0;

    // Serve left and build speed through paddle hits.
    serve = 1'b1;
    serve_dir = 1'b0;
    clk1();
    serve = 1'b0;
    tick = 1'b1;
    hit_x = 1'b1;
    want("hit8_spd", S_SPD, 3);
    want("hit8_x", S_X, 20);
    want("hit8_dx", S_DX, 0);
    want("hit8_bounce", S_BN, 1);
    repeat (8) clk1();
    drain();
    want("hit28_spd", S_SPD, 4);
    want("hit28_dx", S_DX, 0);
    repeat (20) clk1();
    drain();
    hit_x = 1'b0;
    want("left_x", S_X, 12);
    want("left_spd", S_SPD, 4);
    repeat (2) clk1();
    drain();

    // Left miss at speed 4: clamp to X_MIN and score.
    want("missl_x", S_X, 10);
    want("missl_ml", S_ML, 1);
    want("missl_mr", S_MR, 0);
    want("missl_state", S_ST, 2);
    want("missl_y", S_Y, 271);
    clk1();
    drain();
    tick = 1'b0;
    want("missl_ml_clr", S_ML, 0);
    want("missl_hold_state", S_ST, 2);
    clk1();
    drain();
    tick = 1'b1;
    want("hold29_state", S_ST, 2);
    want("hold29_x", S_X, 10);
    want("hold29_y", S_Y, 271);
    repeat (29) clk1();
    drain();
    want("hold30_state", S_ST, 0);
    want("hold30_x", S_X, 20);
    want("hold30_y", S_Y, 240);
    want("hold30_spd", S_SPD, 1);
    clk1();
    drain();
    tick = 1'b0;

    // Serve right; paddle hit at the edge beats the miss, then a real miss.
    serve = 1'b1;
    serve_dir = 1'b1;
    clk1();
    serve = 1'b0;
    tick = 1'b1;
    want("edge_x", S_X, 209);
    want("edge_state", S_ST, 1);
    repeat (189) clk1();
    drain();
    hit_x = 1'b1;
    want("prio_x", S_X, 209);
    want("prio_dx", S_DX, 0);
    want("prio_mr", S_MR, 0);
    want("prio_state", S_ST, 1);
    want("prio_bounce", S_BN, 1);
    clk1();
    drain();
    want("prio2_dx", S_DX, 1);
    clk1();
    drain();
    hit_x = 1'b0;
    want("missr_x", S_X, 210);
    want("missr_mr", S_MR, 1);
    want("missr_ml", S_ML, 0);
    want("missr_state", S_ST, 2);
    clk1();
    drain();
    tick = 1'b0;
    want("missr_mr_clr", S_MR, 0);
    clk1();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
